// File: rtl/fpc_cpl_demux.sv
// Completion receive path: parses 3-DW-header CplD TLPs, realigns payload to qwords and
// writes them to per-channel reorder buffers, flagging the final completion of each tag.
module fpc_cpl_demux #(
    parameter logic [3:0] ENABLE        = 4'b0001,
    parameter int         NBITS_TAG_LOW = 3
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     rx_valid,
    input  logic                     rx_sof,
    input  logic                     rx_eof,
    input  logic [63:0]              rx_data,
    output logic                     wr_valid,
    output logic [1:0]               wr_chan,
    output logic [NBITS_TAG_LOW-1:0] wr_tag_low,
    output logic [5:0]               wr_qaddr,
    output logic [63:0]              wr_data,
    output logic                     done_valid,
    output logic [1:0]               done_chan,
    output logic [NBITS_TAG_LOW-1:0] done_tag_low,
    output logic                     err
);

    // state | meaning
    // IDLE  | waiting for a start-of-frame beat carrying DW0/DW1
    // HDR1  | next beat holds DW2 (tag) and the first payload DW
    // DATA  | one qword write per beat until the length is exhausted
    // DROP  | discard beats up to end of frame, no writes
    typedef enum logic [1:0] {IDLE = 2'd0, HDR1 = 2'd1, DATA = 2'd2, DROP = 2'd3} state_t;

    state_t                   state, state_nx;
    logic [6:0]               len_half_q;
    logic [11:0]              bc_q;
    logic [31:0]              hold_q;
    logic [5:0]               qaddr_q;
    logic [6:0]               remaining_q;
    logic [1:0]               chan_q;
    logic [NBITS_TAG_LOW-1:0] tag_low_q;
    logic                     final_q;

    logic                     hdr_is_cpld, hdr_bad;
    logic [7:0]               tag;
    logic                     tag_bad, bc_bad, fit_bad, hdr1_bad, last_beat;
    logic [11:0]              off_qw;
    logic                     wr_fire, done_fire, err_fire, hdr0_take, hdr1_take;

    assign hdr_is_cpld = (rx_data[30:24] == 7'b100_1010);
    assign hdr_bad     = (rx_data[47:45] != 3'd0) || rx_data[0] ||
                         (rx_data[9:0] == 10'd0) || (rx_data[9:0] > 10'd128);

    assign tag       = rx_data[15:8];
    assign tag_bad   = (tag[7:6] != 2'd0) || tag[3] || !ENABLE[tag[5:4]];
    assign bc_bad    = (bc_q > 12'd512) || (bc_q[2:0] != 3'd0);
    // A completion carries the tail of the request, so its start offset is what bytecount leaves.
    assign off_qw    = (12'd512 - bc_q) >> 3;
    assign fit_bad   = (off_qw + {5'd0, len_half_q}) > 12'd64;
    assign hdr1_bad  = tag_bad || bc_bad || fit_bad;
    assign last_beat = (remaining_q == 7'd1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (rx_valid) begin
            if (rx_sof) begin
                if (!hdr_is_cpld || hdr_bad) state_nx = rx_eof ? IDLE : DROP;
                else                         state_nx = rx_eof ? IDLE : HDR1;
            end else begin
                case (state)
                    IDLE:    state_nx = IDLE;
                    HDR1:    state_nx = rx_eof ? IDLE : (hdr1_bad ? DROP : DATA);
                    DATA:    state_nx = rx_eof ? IDLE : (last_beat ? DROP : DATA);
                    DROP:    state_nx = rx_eof ? IDLE : DROP;
                    default: state_nx = IDLE;
                endcase
            end
        end
    end

    always_comb begin
        hdr0_take = rx_valid && rx_sof;
        hdr1_take = rx_valid && !rx_sof && (state == HDR1);
        wr_fire   = rx_valid && !rx_sof && (state == DATA);
        done_fire = wr_fire && last_beat && rx_eof && final_q;
        err_fire  = 1'b0;
        if (rx_valid) begin
            if (rx_sof)
                err_fire = (hdr_is_cpld && (hdr_bad || rx_eof)) || (state == HDR1) || (state == DATA);
            else
                err_fire = ((state == HDR1) && (hdr1_bad || rx_eof)) ||
                           ((state == DATA) && (last_beat != rx_eof));
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            len_half_q   <= '0;
            bc_q         <= '0;
            hold_q       <= '0;
            qaddr_q      <= '0;
            remaining_q  <= '0;
            chan_q       <= '0;
            tag_low_q    <= '0;
            final_q      <= 1'b0;
            wr_valid     <= 1'b0;
            wr_chan      <= '0;
            wr_tag_low   <= '0;
            wr_qaddr     <= '0;
            wr_data      <= '0;
            done_valid   <= 1'b0;
            done_chan    <= '0;
            done_tag_low <= '0;
            err          <= 1'b0;
        end else begin
            wr_valid   <= wr_fire;
            done_valid <= done_fire;
            err        <= err_fire;
            if (hdr0_take) begin
                len_half_q <= rx_data[7:1];
                bc_q       <= rx_data[43:32];
            end
            if (hdr1_take) begin
                hold_q      <= rx_data[63:32];
                chan_q      <= tag[5:4];
                tag_low_q   <= tag[NBITS_TAG_LOW-1:0];
                qaddr_q     <= off_qw[5:0];
                remaining_q <= len_half_q;
                final_q     <= (bc_q == {2'b00, len_half_q, 3'b000});
            end
            if (wr_fire) begin
                wr_data     <= {rx_data[31:0], hold_q};
                hold_q      <= rx_data[63:32];
                wr_chan     <= chan_q;
                wr_tag_low  <= tag_low_q;
                wr_qaddr    <= qaddr_q;
                qaddr_q     <= qaddr_q + 6'd1;
                remaining_q <= remaining_q - 7'd1;
            end
            if (done_fire) begin
                done_chan    <= chan_q;
                done_tag_low <= tag_low_q;
            end
        end
    end

endmodule

// File: tb/tb_fpc_cpl_demux.sv
// Scoreboard bench for fpc_cpl_demux: a TLP-level model predicts writes/done/err, a monitor checks them.
module tb_fpc_cpl_demux;

    localparam logic [3:0] ENABLE = 4'b0111;
    localparam logic [6:0] CPLD   = 7'b100_1010;
    localparam logic [6:0] MWR    = 7'b100_0000;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        rx_valid, rx_sof, rx_eof;
    logic [63:0] rx_data;
    logic        wr_valid, done_valid, err;
    logic [1:0]  wr_chan, done_chan;
    logic [2:0]  wr_tag_low, done_tag_low;
    logic [5:0]  wr_qaddr;
    logic [63:0] wr_data;

    fpc_cpl_demux #(.ENABLE(ENABLE), .NBITS_TAG_LOW(3)) dut (
        .clock(clock), .reset_n(reset_n), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_eof(rx_eof),
        .rx_data(rx_data), .wr_valid(wr_valid), .wr_chan(wr_chan), .wr_tag_low(wr_tag_low),
        .wr_qaddr(wr_qaddr), .wr_data(wr_data), .done_valid(done_valid), .done_chan(done_chan),
        .done_tag_low(done_tag_low), .err(err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  chan;
        logic [2:0]  tag_low;
        logic [5:0]  qaddr;
        logic [63:0] data;
        logic        done;
    } wr_exp_t;

    wr_exp_t     exp_q[$];
    logic [31:0] dws[$];
    int          n_tests = 0, n_fail = 0, exp_err = 0, seen_err = 0;
    bit          gaps_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin : monitor
        wr_exp_t e;
        forever begin
            @(negedge clock);
            if (reset_n) begin
                if (err) seen_err++;
                if (wr_valid) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_write: got qaddr %0d data %h expected no write", wr_qaddr, wr_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_chan", 64'(wr_chan), 64'(e.chan));
                        check("wr_tag_low", 64'(wr_tag_low), 64'(e.tag_low));
                        check("wr_qaddr", 64'(wr_qaddr), 64'(e.qaddr));
                        check("wr_data", wr_data, e.data);
                        check("done_valid", 64'(done_valid), 64'(e.done));
                        if (e.done) begin
                            check("done_chan", 64'(done_chan), 64'(e.chan));
                            check("done_tag_low", 64'(done_tag_low), 64'(e.tag_low));
                        end
                    end
                end else if (done_valid) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL done_without_write: got done_valid 1 expected 0");
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            rx_valid = 1'b0;
            rx_sof   = 1'($urandom);
            rx_eof   = 1'($urandom);
            rx_data  = {$urandom, $urandom};
        end
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic sof, input logic eof);
        if (gaps_en) idle($urandom_range(0, 2));
        @(posedge clock);
        #1;
        rx_valid = 1'b1;
        rx_sof   = sof;
        rx_eof   = eof;
        rx_data  = d;
    endtask

    task automatic build_dws(input logic [6:0] ft, input int len, input logic [2:0] st,
                             input logic [11:0] bc, input logic [7:0] tag,
                             input logic [31:0] pbase, input bit rnd);
        dws.delete();
        dws.push_back({1'b0, ft, 14'd0, 10'(len)});
        dws.push_back({16'h0100, st, 1'b0, bc});
        dws.push_back({16'h0200, tag, 1'b0, 7'd0});
        for (int i = 0; i < len; i++) dws.push_back(rnd ? $urandom : pbase + 32'(i));
    endtask

    // ndata < 0 sends the whole TLP; otherwise only ndata payload beats follow the header beats.
    task automatic send_tlp(input logic [6:0] ft, input int len, input logic [2:0] st,
                            input logic [11:0] bc, input logic [7:0] tag, input int ndata,
                            input bit with_eof, input logic [31:0] pbase, input bit rnd);
        int      nbeats, off, nw;
        bit      bad;
        wr_exp_t e;
        build_dws(ft, len, st, bc, tag, pbase, rnd);
        off = (512 - int'(bc)) / 8;
        bad = (st != 3'd0) || (len % 2 != 0) || (len == 0) || (len > 128) ||
              (tag[7:6] != 2'd0) || tag[3] || !ENABLE[tag[5:4]] ||
              (int'(bc) > 512) || (int'(bc) % 8 != 0) || (off + len / 2 > 64);
        if (ft == CPLD) begin
            if (bad) exp_err++;
            else begin
                nw = (ndata < 0) ? len / 2 : ndata;
                for (int k = 0; k < nw; k++) begin
                    e.chan    = tag[5:4];
                    e.tag_low = tag[2:0];
                    e.qaddr   = 6'(off + k);
                    e.data    = {dws[4 + 2 * k], dws[3 + 2 * k]};
                    e.done    = (ndata < 0) && (k == nw - 1) && (int'(bc) == len * 4);
                    exp_q.push_back(e);
                end
                if (ndata >= 0) exp_err++;
            end
        end
        nbeats = (ndata < 0) ? (dws.size() + 1) / 2 : 2 + ndata;
        for (int j = 0; j < nbeats; j++)
            drive_beat({(2 * j + 1 < dws.size()) ? dws[2 * j + 1] : $urandom, dws[2 * j]},
                       j == 0, with_eof && (j == nbeats - 1));
    endtask

    task automatic checkpoint(input string name);
        idle(3);
        check({name, "_err"}, 64'(seen_err), 64'(exp_err));
        check({name, "_pending"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        seen_err = exp_err;
    endtask

    initial begin
        int          len, off, ndata, r;
        logic [7:0]  tag;
        logic [11:0] bc;
        logic [2:0]  st;
        logic [6:0]  ft;
        wr_exp_t     e;

        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_sof   = 1'b0;
        rx_eof   = 1'b0;
        rx_data  = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_wr_valid", 64'(wr_valid), 64'd0);
        check("rst_wr_data", wr_data, 64'd0);
        check("rst_done_valid", 64'(done_valid), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        gaps_en = 1'b1;
        send_tlp(CPLD, 128, 3'd0, 12'd512, 8'h12, -1, 1'b1, 32'h1, 1'b0);
        checkpoint("single_512");

        send_tlp(CPLD, 64, 3'd0, 12'd512, 8'h05, -1, 1'b1, 32'h1000, 1'b0);
        send_tlp(CPLD, 64, 3'd0, 12'd256, 8'h05, -1, 1'b1, 32'h2000, 1'b0);
        checkpoint("split_256");

        send_tlp(CPLD, 16, 3'd1, 12'd64, 8'h05, -1, 1'b1, 32'h0, 1'b1);
        checkpoint("status_ur");
        send_tlp(CPLD, 16, 3'd0, 12'd64, 8'h40, -1, 1'b1, 32'h0, 1'b1);
        checkpoint("tag_40");
        send_tlp(MWR, 4, 3'd0, 12'd0, 8'h12, -1, 1'b1, 32'h0, 1'b1);
        checkpoint("mwr_ignored");

        send_tlp(CPLD, 32, 3'd0, 12'd128, 8'h21, 10, 1'b1, 32'h3000, 1'b0);
        checkpoint("early_eof");
        send_tlp(CPLD, 8, 3'd0, 12'd32, 8'h21, -1, 1'b1, 32'h3100, 1'b0);
        checkpoint("after_early_eof");

        send_tlp(CPLD, 16, 3'd0, 12'd64, 8'h13, 3, 1'b0, 32'h4000, 1'b0);
        send_tlp(CPLD, 16, 3'd0, 12'd64, 8'h13, -1, 1'b1, 32'h4100, 1'b0);
        checkpoint("sof_abandon");

        // Reset while in DATA: the write registered on the reset cycle must vanish.
        gaps_en = 1'b0;
        build_dws(CPLD, 16, 3'd0, 12'd64, 8'h02, 32'hA0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            e.chan    = 2'd0;
            e.tag_low = 3'd2;
            e.qaddr   = 6'(56 + k);
            e.data    = {32'hA0 + 32'(2 * k + 1), 32'hA0 + 32'(2 * k)};
            e.done    = 1'b0;
            exp_q.push_back(e);
        end
        for (int j = 0; j < 7; j++) drive_beat({dws[2 * j + 1], dws[2 * j]}, j == 0, 1'b0);
        @(posedge clock);
        #3;
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        #1;
        check("rstmid_wr_valid", 64'(wr_valid), 64'd0);
        check("rstmid_wr_data", wr_data, 64'd0);
        check("rstmid_wr_qaddr", 64'(wr_qaddr), 64'd0);
        check("rstmid_outs", 64'({wr_chan, wr_tag_low, done_valid, done_chan, done_tag_low, err}), 64'd0);
        check("rstmid_pending", 64'(exp_q.size()), 64'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        gaps_en = 1'b1;
        send_tlp(CPLD, 128, 3'd0, 12'd512, 8'h12, -1, 1'b1, 32'h5000, 1'b1);
        checkpoint("after_reset");

        for (int n = 0; n < 60; n++) begin
            tag   = {2'b00, 2'($urandom_range(0, 2)), 1'b0, 3'($urandom_range(0, 7))};
            len   = 2 * $urandom_range(1, 64);
            off   = $urandom_range(0, 64 - len / 2);
            if ($urandom_range(0, 1) == 1) off = 64 - len / 2;
            bc    = 12'(512 - 8 * off);
            ft    = CPLD;
            st    = 3'd0;
            ndata = -1;
            r     = $urandom_range(0, 12);
            case (r)
                0: st = 3'($urandom_range(1, 7));
                1: len = len - 1;
                2: tag[7:6] = 2'($urandom_range(1, 3));
                3: tag[3] = 1'b1;
                4: tag[5:4] = 2'd3;
                5: bc = bc + 12'd4;
                6: bc = 12'(512 - 8 * (64 - len / 2 + 1));
                7: ft = ($urandom_range(0, 1) == 1) ? MWR : 7'b000_0000;
                8: ndata = $urandom_range(0, len / 2 - 1);
                default: ;
            endcase
            send_tlp(ft, len, st, bc, tag, ndata, 1'b1, 32'h0, 1'b1);
            checkpoint("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
